demux_1_4_sched_v: RTL and testbench
====================================

// Module: demux_1_4_sched_v
// PURPOSE
//  Round-robin scheduler that feeds the 1-to-4 demultiplexer. Accepts one word at a time on a
//  valid/ready input and picks an enabled, ready-capable output channel. Drives the demux one-hot
//  select code and holds the word until the chosen channel accepts it.
//  Sits between a single producer and four consumer channels. A channel that stalls past a
//  timeout is skipped.
// PARAMETERS
//  DATA_W    8   width of data word
//  TIMEOUT   15  cycles in SEND without ch ready before re-selecting (>=1; 0 = never skip)
//  CNT_W     8   width of transfer counter
// PORTS
//  i_clk        in   1       clock, all state on rising edge
//  i_rst_n      in   1       reset, asynchronous, active-low
//  i_valid      in   1       producer word valid
//  o_ready      out  1       scheduler can accept a word
//  i_data       in   DATA_W  producer word
//  i_ch_en      in   4       per-channel enable mask (bit n = channel n)
//  i_ch_ready   in   4       per-channel consumer ready
//  o_sel_code   out  4       one-hot demux select; 4'b0000 when nothing offered
//  o_data       out  DATA_W  held word presented to demux input
//  o_busy       out  1       word held (state != IDLE)
//  o_xfer_cnt   out  CNT_W   completed transfers, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE, o_ready=1 after release, o_sel_code=0, o_data=0,
//   o_busy=0, o_xfer_cnt=0, rr pointer=3 (first search starts at ch0), timer=0.
//  FSM IDLE -> SELECT -> SEND -> IDLE. All outputs registered.
//  IDLE: o_ready=1. i_valid&o_ready at edge N: o_data<=i_data, -> SELECT. No accept otherwise.
//  SELECT: o_ready=0, o_sel_code=0. Search ptr+1, ptr+2, ptr+3, ptr (mod 4) for first i_ch_en bit.
//   Found ch -> o_sel_code<=1<<ch, timer<=0, -> SEND. None enabled -> stay SELECT, word kept.
//  SEND: o_sel_code one-hot, o_data stable.
//   i_ch_ready[ch]=1 at edge: transfer done; ptr<=ch; o_xfer_cnt++; o_sel_code<=0; -> IDLE.
//   i_ch_en[ch] falls (without ready) -> o_sel_code<=0, -> SELECT. Word is not lost.
//   TIMEOUT!=0, timer reaches TIMEOUT-1 without ready -> ptr<=ch, -> SELECT (skip this channel
//   first); if it is the only enabled channel it is reselected.
//   Ready and disable on the same edge: ready wins (transfer completes).
//   i_ch_ready of non-selected channels ignored.
//  Latency: accept at edge N -> o_sel_code valid after edge N+1 -> earliest transfer at edge N+2.
//   Next accept at edge N+3 (o_ready high in IDLE). Peak throughput 1 word / 3 cycles.
//  Fairness: after serving ch, next search starts at ch+1; ptr wraps 3 -> 0.
//  Invariants: o_sel_code zero or one-hot; nonzero only in SEND; o_ready=1 only in IDLE;
//   o_busy = !o_ready.
//  Reset mid-operation: held word discarded, all outputs return to reset values immediately.
//  i_data/i_valid ignored while o_ready=0.
// TESTING
//  1 Reset: assert i_rst_n=0 mid-SEND -> o_sel_code=0, o_busy=0, o_xfer_cnt=0 with no clock edge.
//  2 RR: i_ch_en=4'hF, i_ch_ready=4'hF, send 0xA1..0xA5 -> o_sel_code 0001,0010,0100,1000,0001;
//    o_xfer_cnt=5.
//  3 Masking: i_ch_en=4'b1010, ready all -> words go ch1,ch3,ch1; i_ch_en=0 -> stays SELECT,
//    o_ready=0, word 0x5C delivered once en=4'b0100.
//  4 Timeout: TIMEOUT=4, en=4'hF, ch0 ready=0, others 1 -> o_sel_code=0001 for 4 cycles,
//    then 0010 and delivery on ch1.
//  5 Disable mid-SEND: word 0x33 on ch2, drop i_ch_en[2] -> next cycle SELECT, delivered on ch3;
//    ready+disable same edge -> delivered on ch2.
//  6 Wrap: CNT_W=8, 256 transfers -> o_xfer_cnt=0; latency check accept at edge N,
//    transfer at N+2.

Source files
------------

// File: rtl/demux_1_4_sched_v.sv
// Round-robin scheduler that feeds a 1-to-4 demux. It holds one accepted word and offers it to the
// next enabled channel, and moves on to another channel when the offered one stalls or is disabled.
module demux_1_4_sched_v #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [3:0]        i_ch_en,
    input  logic [3:0]        i_ch_ready,
    output logic [3:0]        o_sel_code,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_xfer_cnt,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a word is taken on a rising edge where i_valid && o_ready; a channel takes the
    // word on a rising edge where its o_sel_code bit and its i_ch_ready bit are both high.

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_SEND   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic [3:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        ch_q, ch_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic              found;
    logic [1:0]        pick;
    logic [1:0]        cand;

    // Search order is ptr+1, ptr+2, ptr+3, ptr; the last candidate lets a sole channel be reselected.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && i_ch_en[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        sel_d   = sel_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid && ready_q) begin
                    data_d  = i_data;
                    ready_d = 1'b0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (found) begin
                    ch_d    = pick;
                    sel_d   = 4'b0001 << pick;
                    timer_d = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // Ready outranks a simultaneous disable: the word is already taken.
                if (i_ch_ready[ch_q]) begin
                    ptr_d   = ch_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    sel_d   = 4'b0000;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else if (!i_ch_en[ch_q]) begin
                    sel_d   = 4'b0000;
                    state_d = S_SELECT;
                end else if (TIMEOUT != 0) begin
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        ptr_d   = ch_q;
                        sel_d   = 4'b0000;
                        state_d = S_SELECT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: begin
                sel_d   = 4'b0000;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            sel_q   <= 4'b0000;
            data_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= 2'd3;
            ch_q    <= 2'd0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            timer_q <= timer_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_busy      = !ready_q;
    assign o_sel_code  = sel_q;
    assign o_data      = data_q;
    assign o_xfer_cnt  = cnt_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_demux_1_4_sched_v.sv
// Bench for demux_1_4_sched_v: transaction-level round-robin model predicts the serving channel,
// transfer latency and transfer count for directed and randomized words.
module tb_demux_1_4_sched_v;

    localparam int TO = 4;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data;
    logic [3:0] i_ch_en;
    logic [3:0] i_ch_ready;
    logic [3:0] o_sel_code;
    logic [7:0] o_data;
    logic       o_busy;
    logic [7:0] o_xfer_cnt;
    logic [1:0] o_dbg_state;

    int         n_checks = 0;
    int         n_errors = 0;
    int         m_ptr    = 3;
    logic [7:0] exp_cnt  = 8'd0;

    demux_1_4_sched_v #(.DATA_W(8), .TIMEOUT(TO), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_ch_en(i_ch_en), .i_ch_ready(i_ch_ready),
        .o_sel_code(o_sel_code), .o_data(o_data), .o_busy(o_busy),
        .o_xfer_cnt(o_xfer_cnt), .o_dbg_state(o_dbg_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Round-robin rules with en/ready held static: walk from ptr+1 to the first enabled channel;
    // if it is not ready it times out, becomes the new start point, and the walk repeats.
    task automatic model_pick(input logic [3:0] en, input logic [3:0] rdy,
                              output int ch, output int k);
        int p;
        p  = m_ptr;
        k  = 0;
        ch = -1;
        for (int tries = 0; tries < 8 && ch < 0; tries++) begin
            int c;
            c = -1;
            for (int i = 1; i <= 4; i++)
                if (c < 0 && en[(p + i) % 4]) c = (p + i) % 4;
            if (c < 0) break;
            if (rdy[c]) ch = c;
            else begin
                p = c;
                k++;
            end
        end
        if (ch >= 0) begin
            m_ptr   = ch;
            exp_cnt = exp_cnt + 8'd1;
        end
    endtask

    task automatic accept_word(input logic [7:0] d, input logic [3:0] en, input logic [3:0] rdy);
        for (int k = 0; k < 60 && o_ready !== 1'b1; k++) @(negedge i_clk);
        if (o_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_wait: o_ready=%b required 1", o_ready);
        end
        i_ch_en    = en;
        i_ch_ready = rdy;
        i_data     = d;
        i_valid    = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_data  = 8'($urandom);
    endtask

    // lat counts rising edges from the accept edge to the transfer edge.
    task automatic wait_xfer(output int ch, output int lat, output logic [7:0] dat,
                             output logic [3:0] first_sel);
        ch        = -1;
        lat       = 1;
        dat       = 8'h00;
        first_sel = 4'b0000;
        for (int cyc = 0; cyc < 300; cyc++) begin
            n_checks++;
            if (o_busy !== !o_ready || (o_sel_code & (o_sel_code - 4'd1)) != 4'd0 ||
                (o_sel_code != 4'd0 && o_ready !== 1'b0)) begin
                n_errors++;
                $display("FAIL invariant: sel=%b ready=%b busy=%b", o_sel_code, o_ready, o_busy);
            end
            if (first_sel == 4'b0000) first_sel = o_sel_code;
            if ((o_sel_code & i_ch_ready) != 4'd0) begin
                for (int j = 0; j < 4; j++) if (o_sel_code[j]) ch = j;
                dat = o_data;
                @(negedge i_clk);
                return;
            end
            lat++;
            @(negedge i_clk);
        end
        n_checks++;
        n_errors++;
        $display("FAIL xfer_wait: no transfer within 300 cycles, sel=%b", o_sel_code);
    endtask

    task automatic test_reset();
        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_data     = 8'h00;
        i_ch_en    = 4'h0;
        i_ch_ready = 4'h0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_sel_code !== 4'b0000 ||
            o_data !== 8'h00 || o_xfer_cnt !== 8'h00) begin
            n_errors++;
            $display("FAIL reset: ready=%b busy=%b sel=%b data=%h cnt=%0d required 1 0 0000 00 0",
                     o_ready, o_busy, o_sel_code, o_data, o_xfer_cnt);
        end
        m_ptr   = 3;
        exp_cnt = 8'd0;
    endtask

    task automatic test_round_robin();
        int ch, lat, ech, k;
        logic [7:0] dat;
        logic [3:0] fs;
        for (int w = 0; w < 5; w++) begin
            accept_word(8'hA1 + 8'(w), 4'hF, 4'hF);
            wait_xfer(ch, lat, dat, fs);
            model_pick(4'hF, 4'hF, ech, k);
            n_checks++;
            if (ch != ech || ch != w % 4 || dat !== 8'hA1 + 8'(w) || lat != 2) begin
                n_errors++;
                $display("FAIL rr word %0d: ch=%0d data=%h lat=%0d required ch=%0d data=%h lat=2",
                         w, ch, dat, lat, w % 4, 8'hA1 + 8'(w));
            end
        end
        n_checks++;
        if (o_xfer_cnt !== 8'd5 || o_xfer_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL rr_count: cnt=%0d required 5", o_xfer_cnt);
        end
    endtask

    task automatic test_masking();
        int ch, lat, ech, k;
        int exp_chs[3] = '{1, 3, 1};
        logic [7:0] dat;
        logic [3:0] fs;
        for (int w = 0; w < 3; w++) begin
            accept_word(8'h50 + 8'(w), 4'b1010, 4'hF);
            wait_xfer(ch, lat, dat, fs);
            model_pick(4'b1010, 4'hF, ech, k);
            n_checks++;
            if (ch != ech || ch != exp_chs[w] || dat !== 8'h50 + 8'(w)) begin
                n_errors++;
                $display("FAIL mask word %0d: ch=%0d data=%h required ch=%0d data=%h",
                         w, ch, dat, exp_chs[w], 8'h50 + 8'(w));
            end
        end
        accept_word(8'h5C, 4'b0000, 4'hF);
        repeat (5) @(negedge i_clk);
        n_checks++;
        if (o_ready !== 1'b0 || o_busy !== 1'b1 || o_sel_code !== 4'b0000) begin
            n_errors++;
            $display("FAIL mask_none: ready=%b busy=%b sel=%b required 0 1 0000",
                     o_ready, o_busy, o_sel_code);
        end
        i_ch_en = 4'b0100;
        wait_xfer(ch, lat, dat, fs);
        model_pick(4'b0100, 4'hF, ech, k);
        n_checks++;
        if (ch != ech || ch != 2 || dat !== 8'h5C || o_xfer_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL mask_late: ch=%0d data=%h cnt=%0d required ch=2 data=5c cnt=%0d",
                     ch, dat, o_xfer_cnt, exp_cnt);
        end
    endtask

    task automatic test_timeout();
        int ch, lat, ech, k;
        logic [7:0] dat;
        logic [3:0] fs;
        accept_word(8'h61, 4'b1000, 4'hF);
        wait_xfer(ch, lat, dat, fs);
        model_pick(4'b1000, 4'hF, ech, k);
        accept_word(8'h62, 4'hF, 4'b1110);
        wait_xfer(ch, lat, dat, fs);
        model_pick(4'hF, 4'b1110, ech, k);
        n_checks++;
        if (fs !== 4'b0001 || ch != ech || ch != 1 || dat !== 8'h62 || lat != 2 + k * (TO + 1)) begin
            n_errors++;
            $display("FAIL timeout: first_sel=%b ch=%0d data=%h lat=%0d required 0001 ch=1 data=62 lat=%0d",
                     fs, ch, dat, lat, 2 + k * (TO + 1));
        end
    endtask

    task automatic test_disable();
        int ch, lat;
        logic [7:0] dat;
        logic [3:0] fs;
        // Start point is ch1, so with ch2/ch3 enabled the word goes to ch2 first.
        accept_word(8'h33, 4'b1100, 4'b0000);
        @(negedge i_clk);
        n_checks++;
        if (o_sel_code !== 4'b0100) begin
            n_errors++;
            $display("FAIL disable_sel: sel=%b required 0100", o_sel_code);
        end
        i_ch_en    = 4'b1000;
        i_ch_ready = 4'b1000;
        wait_xfer(ch, lat, dat, fs);
        m_ptr   = 3;
        exp_cnt = exp_cnt + 8'd1;
        n_checks++;
        if (ch != 3 || dat !== 8'h33 || o_xfer_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL disable_move: ch=%0d data=%h cnt=%0d required ch=3 data=33 cnt=%0d",
                     ch, dat, o_xfer_cnt, exp_cnt);
        end
        accept_word(8'h44, 4'b0100, 4'b0000);
        @(negedge i_clk);
        i_ch_en    = 4'b0000;
        i_ch_ready = 4'b0100;
        wait_xfer(ch, lat, dat, fs);
        m_ptr   = 2;
        exp_cnt = exp_cnt + 8'd1;
        n_checks++;
        if (ch != 2 || dat !== 8'h44 || o_ready !== 1'b1 || o_xfer_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL ready_beats_disable: ch=%0d data=%h ready=%b cnt=%0d required ch=2 data=44 1 %0d",
                     ch, dat, o_ready, o_xfer_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        int ch, lat, ech, k;
        logic [7:0] dat, d;
        logic [3:0] fs, en, rdy;
        for (int w = 0; w < 40; w++) begin
            d   = 8'($urandom);
            en  = 4'($urandom_range(1, 15));
            rdy = 4'($urandom_range(0, 15));
            if ((en & rdy) == 4'd0) begin
                for (int j = 3; j >= 0; j--) if (en[j]) ech = j;
                rdy[ech] = 1'b1;
            end
            accept_word(d, en, rdy);
            wait_xfer(ch, lat, dat, fs);
            model_pick(en, rdy, ech, k);
            n_checks++;
            if (ch != ech || dat !== d || lat != 2 + k * (TO + 1) || o_xfer_cnt !== exp_cnt) begin
                n_errors++;
                $display("FAIL random %0d en=%b rdy=%b: ch=%0d data=%h lat=%0d cnt=%0d required ch=%0d data=%h lat=%0d cnt=%0d",
                         w, en, rdy, ch, dat, lat, o_xfer_cnt, ech, d, 2 + k * (TO + 1), exp_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        int ch, lat, ech, k;
        logic [7:0] dat;
        logic [3:0] fs;
        for (int n = 0; n < 300; n++) begin
            accept_word(8'(n), 4'hF, 4'hF);
            wait_xfer(ch, lat, dat, fs);
            model_pick(4'hF, 4'hF, ech, k);
            if (exp_cnt == 8'd0) break;
        end
        n_checks++;
        if (o_xfer_cnt !== 8'd0 || exp_cnt !== 8'd0 || lat != 2 || ch != ech) begin
            n_errors++;
            $display("FAIL wrap: cnt=%0d lat=%0d ch=%0d required cnt=0 lat=2 ch=%0d",
                     o_xfer_cnt, lat, ch, ech);
        end
    endtask

    task automatic test_reset_mid_send();
        int ch, lat, ech, k;
        logic [7:0] dat;
        logic [3:0] fs;
        accept_word(8'h77, 4'hF, 4'h0);
        @(negedge i_clk);
        n_checks++;
        if (o_sel_code == 4'b0000 || o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset: sel=%b busy=%b required nonzero and 1", o_sel_code, o_busy);
        end
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_sel_code !== 4'b0000 || o_busy !== 1'b0 || o_ready !== 1'b1 ||
            o_xfer_cnt !== 8'd0 || o_data !== 8'h00) begin
            n_errors++;
            $display("FAIL async_reset: sel=%b busy=%b ready=%b cnt=%0d data=%h required 0000 0 1 0 00",
                     o_sel_code, o_busy, o_ready, o_xfer_cnt, o_data);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        m_ptr   = 3;
        exp_cnt = 8'd0;
        accept_word(8'h88, 4'hF, 4'hF);
        wait_xfer(ch, lat, dat, fs);
        model_pick(4'hF, 4'hF, ech, k);
        n_checks++;
        if (ch != ech || ch != 0 || dat !== 8'h88 || o_xfer_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL post_reset: ch=%0d data=%h cnt=%0d required ch=0 data=88 cnt=1",
                     ch, dat, o_xfer_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_masking();
        test_timeout();
        test_disable();
        test_random();
        test_wrap();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
